// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier: signed or unsigned WIDTH x WIDTH -> 2*WIDTH product,
// one Booth digit per cycle with a start/busy/done handshake.
module booth_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 nRst,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int XW = WIDTH + 2;
    localparam int AW = WIDTH + 3;
    localparam int CW = $clog2(WIDTH / 2 + 2);
    localparam logic [CW-1:0] STEPS = CW'(WIDTH / 2 + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [XW-1:0]       mcand_q, mcand_d;
    logic [XW-1:0]       mplier_q, mplier_d;
    logic [AW-1:0]       acc_q, acc_d;
    logic                prevBit_q, prevBit_d;
    logic [CW-1:0]       count_q, count_d;
    logic [2*WIDTH-1:0]  p_q, p_d;

    logic [AW-1:0]       mcandWide;
    logic [AW-1:0]       addend;
    logic [AW-1:0]       sum;
    logic [AW-1:0]       accShift;
    logic [XW-1:0]       mplierShift;
    logic [XW-1:0]       aExt;
    logic [XW-1:0]       bExt;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            prevBit_q <= 1'b0;
            count_q   <= '0;
            p_q       <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            prevBit_q <= prevBit_d;
            count_q   <= count_d;
            p_q       <= p_d;
        end
    end

    // Two guard bits make unsigned operands positive in a signed Booth recoding.
    always_comb begin
        aExt = is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
        bExt = is_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
    end

    always_comb begin
        mcandWide = {mcand_q[XW-1], mcand_q};
        addend    = '0;
        unique case ({mplier_q[1:0], prevBit_q})
            3'b000:  addend = '0;
            3'b001:  addend = mcandWide;
            3'b010:  addend = mcandWide;
            3'b011:  addend = {mcandWide[AW-2:0], 1'b0};
            3'b100:  addend = -{mcandWide[AW-2:0], 1'b0};
            3'b101:  addend = -mcandWide;
            3'b110:  addend = -mcandWide;
            3'b111:  addend = '0;
            default: addend = '0;
        endcase
        sum         = acc_q + addend;
        accShift    = {{2{sum[AW-1]}}, sum[AW-1:2]};
        mplierShift = {sum[1:0], mplier_q[XW-1:2]};
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        prevBit_d = prevBit_q;
        count_d   = count_q;
        p_d       = p_q;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            RUN: begin
                busy      = 1'b1;
                acc_d     = accShift;
                mplier_d  = mplierShift;
                prevBit_d = mplier_q[1];
                count_d   = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    p_d     = {accShift[WIDTH-3:0], mplierShift};
                    state_d = DONE;
                end
            end
            default: begin
                done    = (state_q == DONE);
                state_d = IDLE;
                if (start) begin
                    mcand_d   = aExt;
                    mplier_d  = bExt;
                    acc_d     = '0;
                    prevBit_d = 1'b0;
                    count_d   = STEPS;
                    state_d   = RUN;
                end
            end
        endcase
    end

    assign p = p_q;

endmodule

// File: doc/booth_mul_seq.md
Name: booth_mul_seq

Overview:
- Parametrised, multi-cycle radix-4 Booth multiplier for the datapath MUL/MULU path; successor to the combinational 32x32 signed multiplier.
- Supports signed×signed and unsigned×unsigned operands at any even WIDTH.
- Uses a start/done handshake so the control unit can stall on it.
- Trades area for WIDTH/2+1 cycles of latency.

Parameters:
- WIDTH, 32, operand width in bits; must be even and ≥4.

Ports:
- clk  input  1  system clock, rising edge.
- nRst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when the block can accept (IDLE or DONE).
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- a  input  WIDTH  multiplicand; sampled with start.
- b  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high while a multiplication is in progress.
- done  output  1  one-cycle pulse: p holds a new result.
- p  output  2*WIDTH  product; held until the next result is written.

Behaviour:
- Reset is asynchronous and active-low. While nRst=0: state=IDLE, busy=0, done=0, p=0, and all internal registers are cleared. Asserting reset mid-operation aborts the operation; no done is produced.
- IDLE state:
  - busy=0, done=0.
  - If start=1 at a rising edge: latch a and b, each extended to WIDTH+2 bits (sign-extended if is_signed=1, zero-extended otherwise); clear the accumulator; load count=WIDTH/2+1; go to RUN.
- RUN state:
  - busy=1, done=0.
  - Each edge performs one radix-4 Booth step: examine the 3-bit window of the multiplier (including the implicit bit below it); add 0, ±A or ±2A to the upper accumulator; arithmetic-shift the accumulator and multiplier right by 2; decrement count.
  - start is ignored in RUN.
  - On the edge where count goes 1→0: write the low 2*WIDTH bits of the result into p and go to DONE.
- DONE state:
  - busy=0, done=1 for exactly one cycle.
  - If start=1 at this edge: accept new operands exactly as in IDLE and go to RUN (back-to-back operation, no idle bubble). Otherwise go to IDLE.
- Latency: if start is accepted at edge E0, p updates at edge E0+(WIDTH/2+1) and done is high during the following cycle. For WIDTH=32: 17 edges. Throughput is one result per WIDTH/2+2 cycles in back-to-back operation.
- Arithmetic:
  - The internal adder is WIDTH+3 bits so that 2A of an extended operand cannot overflow.
  - The result is exact for every input pair in both modes; there are no overflow or truncation cases.
  - The unsigned result equals the zero-extended a times the zero-extended b. The signed result equals $signed(a)*$signed(b) in 2*WIDTH bits.
- Boundary conditions:
  - Most-negative operands (e.g. 0x80000000) in signed mode need no special case. The extension guard bits guarantee correctness.
  - Operand changes after acceptance have no effect.
  - is_signed toggling during RUN has no effect.
  - p is not cleared on start; it keeps the previous result until the new one is written.

Test Plan:
- Reset mid-RUN (a=3, b=5): assert nRst=0 → busy=0, done=0 and p=0 immediately (asynchronous); after release, no done pulse appears.
- Signed edge cases, WIDTH=32, one at a time. Each must give done exactly 17 edges after acceptance with p as follows:
  - 0x80000000×0x80000000 → 0x4000000000000000
  - 0x80000000×0x7FFFFFFF → 0xC000000080000000
  - 0xFFFFFFFF×0xFFFFFFFF → 0x0000000000000001
  - 0×0 → 0
- Unsigned mode: 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE00000001; 0x80000000×0x00000002 → 0x0000000100000000.
- Back-to-back: hold start=1 continuously with new operands presented each DONE cycle → every accept is followed by a result with one done pulse; no idle cycle between busy periods; start held during RUN is ignored (exactly one result per accept).
- Sweep: signed a=0x80000000 with b=0..4095, then 10k random pairs in both modes. Compare p against a behavioural reference model; zero mismatches required.
- Parameter check: WIDTH=8, signed 0x80×0x80 → 0x4000, unsigned 0xFF×0xFF → 0xFE01, done 5 edges after acceptance.
